// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i core: opcodes, branch funct3 codes,
// sequencer states, halt causes and the branch-compare helper.
package rv32i_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned FUNCT_W  = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, WRITEBACK, HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        HC_NONE, HC_EBREAK, HC_ILLEGAL, HC_MISALIGNED
    } halt_cause_e;

    typedef enum logic [2:0] {
        CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH
    } instr_class_e;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic t;
        case (funct3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) < $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended I/B/J/U immediates extracted from an instruction word.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm_i_c,
    output logic [XLEN-1:0] imm_b_c,
    output logic [XLEN-1:0] imm_j_c,
    output logic [XLEN-1:0] imm_u_c
);

    assign imm_i_c = {{20{instr[31]}}, instr[31:20]};
    assign imm_b_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u_c = {instr[31:12], 12'b0};

endmodule

// File: rtl/rv32i_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control for the rv32i core;
// owns the PC and issues at most one regfile write per instruction.
module rv32i_sequencer
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_result,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] pc,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    seq_state_e      state_q, state_d;
    instr_class_e    cls_q, dec_cls_c;
    halt_cause_e     cause_q;
    logic [XLEN-1:0] ir_q, imm_q, rs2_q, next_pc_q;
    logic [XLEN-1:0] imm_i_c, imm_b_c, imm_j_c, imm_u_c;
    logic [XLEN-1:0] dec_imm_c, target_c, wb_data_c, jalr_sum_c;
    logic            dec_legal_c, dec_ebreak_c, alu_f7_c;
    logic            fetch_hit_c, taken_c, redirect_c, writes_c, misaligned_c;

    imm_gen u_imm_gen (
        .instr   (ir_q),
        .imm_i_c (imm_i_c),
        .imm_b_c (imm_b_c),
        .imm_j_c (imm_j_c),
        .imm_u_c (imm_u_c)
    );

    assign imem_addr  = pc;
    assign rs1_addr   = ir_q[19:15];
    assign rs2_addr   = ir_q[24:20];
    assign halt_cause = cause_q;

    assign fetch_hit_c  = imem_req && imem_valid;
    assign dec_ebreak_c = (ir_q == EBREAK_INSTR);
    assign alu_f7_c     = ir_q[30] && ((ir_q[6:0] == OPC_OP) ||
                          ((ir_q[6:0] == OPC_OP_IMM) && (ir_q[14:12] == 3'b101)));
    assign taken_c      = (cls_q == CLS_BRANCH) && branch_taken(ir_q[14:12], alu_a, rs2_q);
    assign jalr_sum_c   = alu_a + imm_q;

    // Opcode classification and immediate selection for the latched instruction
    always_comb begin
        dec_cls_c   = CLS_OP;
        dec_imm_c   = imm_i_c;
        dec_legal_c = 1'b1;
        case (ir_q[6:0])
            OPC_OP:     dec_cls_c = CLS_OP;
            OPC_OP_IMM: dec_cls_c = CLS_OP_IMM;
            OPC_LUI:    begin dec_cls_c = CLS_LUI;   dec_imm_c = imm_u_c; end
            OPC_AUIPC:  begin dec_cls_c = CLS_AUIPC; dec_imm_c = imm_u_c; end
            OPC_JAL:    begin dec_cls_c = CLS_JAL;   dec_imm_c = imm_j_c; end
            OPC_JALR:   dec_cls_c = CLS_JALR;
            OPC_BRANCH: begin
                dec_cls_c   = CLS_BRANCH;
                dec_imm_c   = imm_b_c;
                dec_legal_c = (ir_q[14:13] != 2'b01);
            end
            OPC_SYSTEM: dec_legal_c = 1'b0;
            default:    dec_legal_c = 1'b0;
        endcase
    end

    // Next-PC and writeback data resolution during EXECUTE
    always_comb begin
        target_c   = pc + 32'd4;
        redirect_c = 1'b0;
        writes_c   = 1'b1;
        wb_data_c  = alu_result;
        case (cls_q)
            CLS_OP, CLS_OP_IMM: ;
            CLS_LUI:   wb_data_c = imm_q;
            CLS_AUIPC: wb_data_c = pc + imm_q;
            CLS_JAL: begin
                target_c   = pc + imm_q;
                redirect_c = 1'b1;
                wb_data_c  = pc + 32'd4;
            end
            CLS_JALR: begin
                target_c   = {jalr_sum_c[XLEN-1:1], 1'b0};
                redirect_c = 1'b1;
                wb_data_c  = pc + 32'd4;
            end
            CLS_BRANCH: begin
                writes_c = 1'b0;
                if (taken_c) begin
                    target_c   = pc + imm_q;
                    redirect_c = 1'b1;
                end
            end
            default: writes_c = 1'b0;
        endcase
    end

    assign misaligned_c = redirect_c && target_c[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (fetch_hit_c) state_d = DECODE;
            DECODE:    state_d = (dec_ebreak_c || !dec_legal_c) ? HALT : EXECUTE;
            EXECUTE:   state_d = misaligned_c ? HALT : WRITEBACK;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir_q      <= '0;
            cls_q     <= CLS_OP;
            imm_q     <= '0;
            rs2_q     <= '0;
            next_pc_q <= '0;
            cause_q   <= HC_NONE;
            imem_req  <= 1'b0;
            halted    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_funct <= '0;
            rd_we     <= 1'b0;
            rd_addr   <= '0;
            rd_wdata  <= '0;
        end else begin
            imem_req <= (state_d == FETCH);
            halted   <= (state_d == HALT);
            rd_we    <= 1'b0;
            case (state_q)
                FETCH: if (fetch_hit_c) ir_q <= imem_rdata;
                DECODE: begin
                    cls_q     <= dec_cls_c;
                    imm_q     <= dec_imm_c;
                    alu_a     <= rs1_data;
                    rs2_q     <= rs2_data;
                    alu_b     <= (ir_q[6:0] == OPC_OP_IMM) ? imm_i_c : rs2_data;
                    alu_funct <= {alu_f7_c, ir_q[14:12]};
                    if (dec_ebreak_c)      cause_q <= HC_EBREAK;
                    else if (!dec_legal_c) cause_q <= HC_ILLEGAL;
                end
                EXECUTE: begin
                    if (misaligned_c) begin
                        cause_q <= HC_MISALIGNED;
                    end else begin
                        rd_we     <= writes_c && (ir_q[11:7] != 5'd0);
                        rd_addr   <= ir_q[11:7];
                        rd_wdata  <= wb_data_c;
                        next_pc_q <= target_c;
                    end
                end
                WRITEBACK: pc <= next_pc_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Directed bench for rv32i_sequencer: ISA-level expected results per
// instruction plus a per-cycle invariant monitor.
module tb_rv32i_sequencer;

    logic        clk, rst_n;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, alu_a, alu_b, alu_result, rd_wdata, pc;
    logic [3:0]  alu_funct;
    logic        rd_we, halted;
    logic [1:0]  halt_cause;

    logic [31:0] rf [32];
    logic [31:0] last_instr;
    logic [31:0] exp_pc;
    logic [31:0] g_rd, g_wd, g_next;
    int          g_we_cnt;
    int          tests = 0;
    int          fails = 0;

    rv32i_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_result(alu_result),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .pc(pc), .halted(halted), .halt_cause(halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model: {funct7[5], funct3} selects the RV32I operation
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
        logic [31:0] r;
        case (f[2:0])
            3'b000:  r = f[3] ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = f[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign rs1_data   = rf[rs1_addr];
    assign rs2_data   = rf[rs2_addr];
    assign alu_result = alu_fn(alu_a, alu_b, alu_funct);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Architectural effect of one instruction
    task automatic model(input logic [31:0] instr, input logic [31:0] cpc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         output logic we, output logic [4:0] rd, output logic [31:0] wd,
                         output logic [31:0] nxt, output logic halt, output logic [1:0] cause);
        logic [2:0]  f3;
        logic [31:0] ii, ib, ij, iu;
        logic        redir, tk;
        f3 = instr[14:12];
        rd = instr[11:7];
        ii = {{20{instr[31]}}, instr[31:20]};
        ib = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        ij = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        iu = {instr[31:12], 12'b0};
        we = 1'b0; wd = 32'h0; nxt = cpc + 32'd4; halt = 1'b0; cause = 2'd0; redir = 1'b0;
        if (instr == 32'h0010_0073) begin
            halt = 1'b1; cause = 2'd1;
        end else begin
            case (instr[6:0])
                7'b0110011: begin we = 1'b1; wd = alu_fn(r1, r2, {instr[30], f3}); end
                7'b0010011: begin we = 1'b1; wd = alu_fn(r1, ii, {(f3 == 3'b101) & instr[30], f3}); end
                7'b0110111: begin we = 1'b1; wd = iu; end
                7'b0010111: begin we = 1'b1; wd = cpc + iu; end
                7'b1101111: begin we = 1'b1; wd = cpc + 32'd4; nxt = cpc + ij; redir = 1'b1; end
                7'b1100111: begin we = 1'b1; wd = cpc + 32'd4; nxt = (r1 + ii) & ~32'h1; redir = 1'b1; end
                7'b1100011: begin
                    tk = 1'b0;
                    case (f3)
                        3'd0: tk = (r1 == r2);
                        3'd1: tk = (r1 != r2);
                        3'd4: tk = ($signed(r1) < $signed(r2));
                        3'd5: tk = ($signed(r1) >= $signed(r2));
                        3'd6: tk = (r1 < r2);
                        3'd7: tk = (r1 >= r2);
                        default: begin halt = 1'b1; cause = 2'd2; end
                    endcase
                    if (tk) begin nxt = cpc + ib; redir = 1'b1; end
                end
                default: begin halt = 1'b1; cause = 2'd2; end
            endcase
            if (!halt && redir && nxt[1]) begin halt = 1'b1; cause = 2'd3; end
        end
        we = we && !halt && (rd != 5'd0);
    endtask

    // Per-cycle invariants on the DUT outputs
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("mon_rs1_addr", 32'(rs1_addr), 32'(last_instr[19:15]));
            chk("mon_rs2_addr", 32'(rs2_addr), 32'(last_instr[24:20]));
            chk("mon_we_excl", 32'(rd_we & (imem_req | halted)), 32'd0);
            chk("mon_halt_req", 32'(halted & imem_req), 32'd0);
            if (!halted) chk("mon_cause_idle", 32'(halt_cause), 32'd0);
            if (rd_we) chk("mon_we_x0", 32'(rd_addr == 5'd0), 32'd0);
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0; imem_valid = 1'b0; last_instr = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_pc", pc, 32'h0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_cause", 32'(halt_cause), 32'd0);
            chk("rst_we", 32'(rd_we), 32'd0);
            chk("rst_wdata", rd_wdata, 32'h0);
            chk("rst_alu_a", alu_a, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        exp_pc = 32'h0;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int delay);
        logic        e_we, e_halt;
        logic [4:0]  e_rd;
        logic [31:0] e_wd, e_nxt;
        logic [1:0]  e_cause;
        int          cyc, we_cyc;
        model(instr, exp_pc, rf[instr[19:15]], rf[instr[24:20]], e_we, e_rd, e_wd, e_nxt, e_halt, e_cause);
        cyc = 0;
        while (!imem_req && cyc < 10) begin @(negedge clk); cyc++; end
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("fetch_wait_req", 32'(imem_req), 32'd1);
            chk("fetch_wait_pc", pc, exp_pc);
        end
        imem_valid = 1'b1; imem_rdata = instr; last_instr = instr;
        @(negedge clk);
        imem_valid = 1'b0; imem_rdata = $urandom;
        g_we_cnt = 0; we_cyc = 0; g_rd = 32'h0; g_wd = 32'h0;
        cyc = 1;
        forever begin
            if (rd_we) begin
                g_we_cnt++; we_cyc = cyc; g_rd = 32'(rd_addr); g_wd = rd_wdata;
            end
            if (imem_req || halted || cyc >= 12) break;
            @(negedge clk);
            cyc++;
        end
        g_next = imem_addr;
        chk("we_count", 32'(g_we_cnt), e_we ? 32'd1 : 32'd0);
        if (e_halt) begin
            chk("halt_latency", 32'(cyc), (e_cause == 2'd3) ? 32'd3 : 32'd2);
            chk("halted", 32'(halted), 32'd1);
            chk("halt_cause", 32'(halt_cause), 32'(e_cause));
            chk("halt_pc", pc, exp_pc);
            for (int i = 0; i < 4; i++) begin
                imem_valid = 1'b1; imem_rdata = 32'h0010_0293;
                @(negedge clk);
                chk("halt_hold", 32'(halted), 32'd1);
                chk("halt_req", 32'(imem_req), 32'd0);
                chk("halt_pc_frozen", pc, exp_pc);
                chk("halt_we", 32'(rd_we), 32'd0);
            end
            imem_valid = 1'b0;
        end else begin
            chk("cpi", 32'(cyc), 32'd4);
            chk("next_fetch", imem_addr, e_nxt);
            if (e_we) begin
                chk("we_cycle", 32'(we_cyc), 32'd3);
                chk("wb_rd", g_rd, 32'(e_rd));
                chk("wb_data", g_wd, e_wd);
            end
            exp_pc = e_nxt;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
        last_instr = 32'h0; exp_pc = 32'h0;

        do_reset(3);
        run_instr(32'h0010_0293, 0);                 // addi x5,x0,1
        chk("pin_addi_rd", g_rd, 32'd5);
        chk("pin_addi_wd", g_wd, 32'd1);
        chk("pin_addi_next", g_next, 32'h4);
        run_instr(32'h01C0_006F, 0);                 // jal x0,+28
        chk("pin_jal0_next", g_next, 32'h20);
        rf[1] = 32'd7; rf[2] = 32'd7;
        run_instr(32'h0020_8463, 0);                 // beq taken
        chk("pin_beq_taken", g_next, 32'h28);
        chk("pin_beq_nowe", 32'(g_we_cnt), 32'd0);
        run_instr(32'hFF9F_F06F, 0);                 // jal x0,-8
        chk("pin_jal_back", g_next, 32'h20);
        rf[2] = 32'd8;
        run_instr(32'h0020_8463, 0);                 // beq not taken
        chk("pin_beq_nt", g_next, 32'h24);
        rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
        run_instr(32'h0020_C463, 0);                 // blt taken
        chk("pin_blt", g_next, 32'h2C);
        run_instr(32'h0020_E463, 0);                 // bltu not taken
        chk("pin_bltu", g_next, 32'h30);
        run_instr(32'h0100_0067, 0);                 // jalr x0,16(x0)
        chk("pin_jalr", g_next, 32'h10);
        run_instr(32'h00C0_00EF, 0);                 // jal x1,+12
        chk("pin_jal_rd", g_rd, 32'd1);
        chk("pin_jal_link", g_wd, 32'h14);
        chk("pin_jal_next", g_next, 32'h1C);
        run_instr(32'h1234_51B7, 3);                 // lui x3 with delayed fetch
        chk("pin_lui", g_wd, 32'h1234_5000);
        run_instr(32'h0000_1217, 0);                 // auipc x4,1
        chk("pin_auipc", g_wd, 32'h1020);
        rf[1] = 32'd10; rf[2] = 32'd3;
        run_instr(32'h4020_8333, 0);                 // sub x6,x1,x2
        chk("pin_sub", g_wd, 32'd7);
        rf[1] = 32'h8000_0000;
        run_instr(32'h4040_D393, 0);                 // srai x7,x1,4
        chk("pin_srai", g_wd, 32'hF800_0000);
        run_instr(32'h0050_0013, 0);                 // addi x0,x0,5
        chk("pin_x0_nowe", 32'(g_we_cnt), 32'd0);
        run_instr(32'h4000_8413, 0);                 // addi x8,x1,1024
        chk("pin_addi_bit30", g_wd, 32'h8000_0400);
        run_instr(32'h0020_A463, 0);                 // branch funct3 010
        chk("pin_illegal", 32'(halt_cause), 32'd2);

        do_reset(3);
        run_instr(32'h0010_0073, 0);                 // ebreak
        chk("pin_ebreak", 32'(halt_cause), 32'd1);

        do_reset(3);
        run_instr(32'h0020_00E7, 0);                 // jalr x1,2(x0) misaligned
        chk("pin_misaligned", 32'(halt_cause), 32'd3);
        chk("pin_misaligned_pc", pc, 32'h0);

        do_reset(3);
        imem_valid = 1'b1; imem_rdata = 32'h0010_0293; last_instr = 32'h0010_0293;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; last_instr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_we", 32'(rd_we), 32'd0);
            chk("abort_pc", pc, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_refetch_req", 32'(imem_req), 32'd1);
        chk("abort_refetch_addr", imem_addr, 32'h0);
        chk("abort_no_we", 32'(rd_we), 32'd0);
        exp_pc = 32'h0;
        run_instr(32'h0010_0293, 0);
        chk("pin_restart_wd", g_wd, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_sequencer.md
Name: rv32i_sequencer

Overview:
Multi-cycle control FSM for the rv32i core. It fetches each instruction over a valid-handshaked instruction-memory port and decodes it. It drives regfile read addresses, feeds operands to the external ALU, resolves B-type and jump control flow, and issues one regfile write per instruction. It sits in top between instruction memory, regfile_inst and the ALU, and owns the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request; high throughout FETCH.
imem_addr  out  32  fetch address; equals pc.
imem_valid  in  1  imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction word.
rs1_addr  out  5  instr[19:15] of the latched instruction.
rs2_addr  out  5  instr[24:20] of the latched instruction.
rs1_data  in  32  regfile read data for rs1, combinational.
rs2_data  in  32  regfile read data for rs2, combinational.
alu_a  out  32  ALU operand A.
alu_b  out  32  ALU operand B.
alu_funct  out  4  {funct7[5], funct3}.
alu_result  in  32  ALU result, combinational.
rd_we  out  1  regfile write strobe.
rd_addr  out  5  regfile write address.
rd_wdata  out  32  regfile write data.
pc  out  32  architectural PC.
halted  out  1  core stopped.
halt_cause  out  2  0 none, 1 ebreak, 2 illegal, 3 misaligned.

Behaviour:
- Reset is asynchronous. State goes to FETCH, pc=RESET_PC, and the instruction register is cleared. imem_req, rd_we and halted are 0, halt_cause is 0, and all data outputs are 0.
- FETCH: imem_req=1. The block stays in FETCH until imem_valid=1, then latches imem_rdata and goes to DECODE. imem_valid is ignored in every other state.
- DECODE (1 cycle): classify the opcode and register rs1_data/rs2_data and the immediate (from imm_gen).
  - Supported: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, and EBREAK (32'h0010_0073).
  - Anything else, including BRANCH funct3 010 or 011, goes to HALT with cause 2.
- EXECUTE (1 cycle): drive alu_a, alu_b and alu_funct, and sample alu_result into the result register.
  - alu_a = rs1.
  - alu_b = rs2 for OP, I-imm for OP-IMM.
  - alu_funct[3] = funct7[5] for OP, and for OP-IMM only when funct3=101; otherwise 0.
  - Branch compare: BEQ/BNE equality, BLT/BGE signed, BLTU/BGEU unsigned.
  - Compute next_pc as follows:
    - taken branch: pc+B-imm
    - JAL: pc+J-imm
    - JALR: (rs1+I-imm) with bit0 cleared
    - everything else: pc+4
  - If next_pc[1] is set on a taken branch, JAL or JALR, go to HALT with cause 3; pc is held and no write occurs.
- WRITEBACK (1 cycle): rd_we=1 for exactly this cycle, and only if the class writes and rd!=0. Writes to x0 are suppressed.
  - rd_wdata: ALU result for OP/OP-IMM, U-imm for LUI, pc+U-imm for AUIPC, pc+4 for JAL/JALR.
  - pc <= next_pc; then return to FETCH.
- Throughput is 4 cycles per instruction when imem_valid is returned in the first FETCH cycle.
- HALT is terminal until reset. In HALT: halted=1, halt_cause held, imem_req=0, rd_we=0, pc frozen. EBREAK enters HALT from DECODE with cause 1.
- rd_we is 0 outside WRITEBACK. rs1_addr/rs2_addr always reflect the latched instruction.
- All arithmetic is 32-bit modulo; PC wraps at 2^32 with no flag.
- Reset asserted in any state aborts the instruction; no partial write occurs.

Decomposition:
- rv32i_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM)
  - branch funct3 constants
  - seq_state_e (FETCH, DECODE, EXECUTE, WRITEBACK, HALT)
  - halt_cause_e
- Sub-module imm_gen: combinational; takes instr and produces the I, B, J and U sign-extended immediates.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. During reset imem_req=0 and pc=0. First cycle after release: imem_req=1, imem_addr=0.
- ADDI x5,x0,1 (0x00100293), with an ALU model returning 1 and imem_valid immediate:
  - rd_we pulses once in cycle 4 with rd_addr=5 and rd_wdata=1.
  - The next fetch has imem_addr=4.
- BEQ x1,x2,+8 (0x00208463) at pc=0x20:
  - rs1=rs2=7 gives next imem_addr=0x28.
  - rs2=8 gives next imem_addr=0x24.
  - rd_we is never asserted.
- rs1=0xFFFF_FFFF, rs2=1: BLT is taken and BLTU is not taken. Funct3 010 halts with halt_cause=2.
- JAL x1,+12 (0x00C000EF) at pc=0x10 writes x1=0x14 and the next fetch is 0x1C. A JALR whose target has bit1=1 gives halted=1, halt_cause=3, pc unchanged, and no write.
- imem_valid delayed 3 cycles stays in FETCH with imem_req=1 until valid. rst_n pulsed low during EXECUTE leaves rd_we at 0 and restarts the fetch at RESET_PC. EBREAK gives halt_cause=1.
